// File: rtl/sift_frame_builder_if.sv
// Event-in / frame-out bundle for sift_frame_builder.
// The slave modport is the builder; the master modport is its producer/consumer side.
interface sift_frame_builder_if #(
  parameter int FRAME_LEN = 80,
  parameter int IDX_W     = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 s_bit;
  logic                 s_basis;
  logic                 r_bit;
  logic                 r_basis;
  logic                 r_detect;
  logic                 flush;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [FRAME_LEN-1:0] sender_sifted;
  logic [FRAME_LEN-1:0] sender_svalid;
  logic [FRAME_LEN-1:0] receiver_sifted;
  logic [FRAME_LEN-1:0] receiver_svalid;
  logic [IDX_W-1:0]     frame_fill;
  logic [IDX_W-1:0]     frame_err_cnt;

  modport master (
    output in_valid, s_bit, s_basis, r_bit, r_basis, r_detect, flush, frame_ready,
    input  in_ready, frame_valid, sender_sifted, sender_svalid,
           receiver_sifted, receiver_svalid, frame_fill, frame_err_cnt
  );

  modport slave (
    input  in_valid, s_bit, s_basis, r_bit, r_basis, r_detect, flush, frame_ready,
    output in_ready, frame_valid, sender_sifted, sender_svalid,
           receiver_sifted, receiver_svalid, frame_fill, frame_err_cnt
  );
endinterface

// File: rtl/sift_frame_builder.sv
// Packs sifted detection events into FRAME_LEN-slot frames and hands them off with valid/ready.
// Define SIFT_QBER_EST_EN to count per-frame bit errors on frame_err_cnt (tied to 0 otherwise).
module sift_frame_builder #(
  parameter int FRAME_LEN = 80,
  parameter int IDX_W     = 7
) (
  input logic                clk,
  input logic                rst_n,
  sift_frame_builder_if.slave bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     fill_q;
  logic [FRAME_LEN-1:0] s_sift_q;
  logic [FRAME_LEN-1:0] r_sift_q;
  logic [FRAME_LEN-1:0] svalid_q;

  logic accept;
  logic slot_valid;
  logic last_slot;
  logic take_flush;
  logic close_frame;
  logic handshake;

  // A flush with an empty frame is only honoured if this cycle's event fills slot 0.
  assign accept      = (state_q == FILL) && bus.in_valid;
  assign slot_valid  = bus.r_detect && (bus.s_basis == bus.r_basis);
  assign last_slot   = accept && (idx_q == IDX_W'(FRAME_LEN - 1));
  assign take_flush  = (state_q == FILL) && bus.flush && (accept || (idx_q != '0));
  assign close_frame = last_slot || take_flush;
  assign handshake   = (state_q == HOLD) && bus.frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (close_frame) state_d = HOLD;
      HOLD:    if (handshake)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready    = rst_n && (state_q == FILL);
    bus.frame_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      fill_q   <= '0;
      s_sift_q <= '0;
      r_sift_q <= '0;
      svalid_q <= '0;
    end else if (handshake) begin
      idx_q    <= '0;
      fill_q   <= '0;
      s_sift_q <= '0;
      r_sift_q <= '0;
      svalid_q <= '0;
    end else if (accept) begin
      s_sift_q[idx_q] <= bus.s_bit;
      r_sift_q[idx_q] <= bus.r_bit;
      svalid_q[idx_q] <= slot_valid;
      idx_q           <= idx_q + IDX_W'(1);
      if (close_frame) begin
        fill_q <= idx_q + IDX_W'(1);
      end
    end else if (take_flush) begin
      fill_q <= idx_q;
    end
  end

  assign bus.sender_sifted   = s_sift_q;
  assign bus.receiver_sifted = r_sift_q;
  assign bus.sender_svalid   = svalid_q;
  assign bus.receiver_svalid = svalid_q;
  assign bus.frame_fill      = fill_q;

`ifdef SIFT_QBER_EST_EN
  logic [IDX_W-1:0] err_q;

  // Saturating count of kept slots whose bits disagree; held with the frame until handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (handshake) begin
      err_q <= '0;
    end else if (accept && slot_valid && (bus.s_bit != bus.r_bit) && (err_q != '1)) begin
      err_q <= err_q + IDX_W'(1);
    end
  end

  assign bus.frame_err_cnt = err_q;
`else
  assign bus.frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_sift_frame_builder.sv
// Self-checking bench for sift_frame_builder: slot-rule table, directed frame scenarios,
// and a randomized run against a queue-based frame model.
module tb_sift_frame_builder;

  localparam int FRAME_LEN = 80;
  localparam int IDX_W     = 7;
  localparam logic [FRAME_LEN-1:0] PAT_A  = {20{4'hA}};
  localparam logic [FRAME_LEN-1:0] PAT_5  = {20{4'h5}};
  localparam logic [FRAME_LEN-1:0] ONES   = {FRAME_LEN{1'b1}};
  localparam logic [FRAME_LEN-1:0] LOW6   = 80'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sift_frame_builder_if #(.FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) bus ();

  sift_frame_builder #(.FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic s;
    logic r;
    logic v;
  } slot_t;

  typedef struct {
    logic sb;
    logic sbs;
    logic rb;
    logic rbs;
    logic rd;
    logic exp_v;
    logic exp_e;
  } vec_t;

  // Model: the frame is simply the ordered list of accepted events plus a "handed over" flag.
  slot_t mq[$];
  bit    m_hold;
  int    checks = 0;
  int    passes = 0;

  task automatic checkVal(input string name, input logic [FRAME_LEN-1:0] act,
                          input logic [FRAME_LEN-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelStep(input logic iv, sb, sbs, rb, rbs, rd, fl, fr);
    slot_t t;
    if (!m_hold) begin
      if (iv) begin
        t.s = sb;
        t.r = rb;
        t.v = rd && (sbs == rbs);
        mq.push_back(t);
      end
      if ((iv && mq.size() == FRAME_LEN) || (fl && mq.size() > 0)) m_hold = 1'b1;
    end else if (fr) begin
      mq.delete();
      m_hold = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [FRAME_LEN-1:0] ss, sv, rs;
    logic [IDX_W-1:0]     fill, err;
`ifdef SIFT_QBER_EST_EN
    int e;
    e = 0;
`endif
    ss = '0;
    sv = '0;
    rs = '0;
    foreach (mq[k]) begin
      ss[k] = mq[k].s;
      rs[k] = mq[k].r;
      sv[k] = mq[k].v;
`ifdef SIFT_QBER_EST_EN
      if (mq[k].v && (mq[k].s != mq[k].r)) e++;
`endif
    end
    fill = m_hold ? IDX_W'(mq.size()) : '0;
`ifdef SIFT_QBER_EST_EN
    err = IDX_W'((e > (2**IDX_W - 1)) ? (2**IDX_W - 1) : e);
`else
    err = '0;
`endif
    checkVal({tag, " in_ready"},        FRAME_LEN'(bus.in_ready),    FRAME_LEN'(rst_n & ~m_hold));
    checkVal({tag, " frame_valid"},     FRAME_LEN'(bus.frame_valid), FRAME_LEN'(m_hold));
    checkVal({tag, " sender_sifted"},   bus.sender_sifted,   ss);
    checkVal({tag, " receiver_sifted"}, bus.receiver_sifted, rs);
    checkVal({tag, " sender_svalid"},   bus.sender_svalid,   sv);
    checkVal({tag, " receiver_svalid"}, bus.receiver_svalid, sv);
    checkVal({tag, " frame_fill"},      FRAME_LEN'(bus.frame_fill),    FRAME_LEN'(fill));
    checkVal({tag, " frame_err_cnt"},   FRAME_LEN'(bus.frame_err_cnt), FRAME_LEN'(err));
  endtask

  task automatic applyStimulus(input logic iv, sb, sbs, rb, rbs, rd, fl, fr, input string tag);
    bus.in_valid    = iv;
    bus.s_bit       = sb;
    bus.s_basis     = sbs;
    bus.r_bit       = rb;
    bus.r_basis     = rbs;
    bus.r_detect    = rd;
    bus.flush       = fl;
    bus.frame_ready = fr;
    @(posedge clk);
    modelStep(iv, sb, sbs, rb, rbs, rd, fl, fr);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input logic fr, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fr, tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t table_v[8];
    int   exp_err;
    logic par;

    table_v[0] = '{1, 0, 1, 0, 1, 1, 0};
    table_v[1] = '{1, 1, 0, 1, 1, 1, 1};
    table_v[2] = '{0, 0, 1, 1, 1, 0, 0};
    table_v[3] = '{0, 1, 0, 1, 0, 0, 0};
    table_v[4] = '{0, 1, 1, 1, 1, 1, 1};
    table_v[5] = '{1, 0, 0, 1, 1, 0, 0};
    table_v[6] = '{1, 1, 0, 1, 0, 0, 0};
    table_v[7] = '{0, 0, 0, 0, 1, 1, 0};

    bus.in_valid = 0; bus.s_bit = 0; bus.s_basis = 0; bus.r_bit = 0;
    bus.r_basis = 0; bus.r_detect = 0; bus.flush = 0; bus.frame_ready = 0;
    m_hold = 0;
    mq.delete();

    // Reset state, both while held and just after release
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset active");
    rst_n = 1'b1;
    #1;
    checkOutput("reset released");

    // Slot-rule table: eight events, the last one carries the flush
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, table_v[i].sb, table_v[i].sbs, table_v[i].rb, table_v[i].rbs,
                    table_v[i].rd, (i == 7), 1'b0, $sformatf("table[%0d]", i));
    end
    exp_err = 0;
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("table[%0d] svalid", i), FRAME_LEN'(bus.sender_svalid[i]),
               FRAME_LEN'(table_v[i].exp_v));
      checkVal($sformatf("table[%0d] receiver_sifted", i), FRAME_LEN'(bus.receiver_sifted[i]),
               FRAME_LEN'(table_v[i].rb));
      if (table_v[i].exp_e) exp_err++;
    end
    checkVal("table frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(8));
`ifdef SIFT_QBER_EST_EN
    checkVal("table frame_err_cnt", FRAME_LEN'(bus.frame_err_cnt), FRAME_LEN'(exp_err));
`else
    checkVal("table frame_err_cnt", FRAME_LEN'(bus.frame_err_cnt), FRAME_LEN'(0));
`endif
    idle(1'b1, "table handshake");

    // T1: full frame with parity bits
    for (int k = 0; k < FRAME_LEN; k++) begin
      par = k[0];
      applyStimulus(1'b1, par, 1'b0, par, 1'b0, 1'b1, 1'b0, 1'b0, "T1 fill");
    end
    checkVal("T1 frame_valid", FRAME_LEN'(bus.frame_valid), FRAME_LEN'(1));
    checkVal("T1 frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(80));
    checkVal("T1 sender_svalid", bus.sender_svalid, ONES);
    checkVal("T1 sender_sifted", bus.sender_sifted, PAT_A);
    checkVal("T1 receiver_sifted", bus.receiver_sifted, PAT_A);
    idle(1'b1, "T1 handshake");

    // T2: odd slots disagree on basis, slot 4 not detected
    for (int k = 0; k < FRAME_LEN; k++) begin
      par = k[0];
      applyStimulus(1'b1, par, 1'b0, par, par, (k != 4), 1'b0, 1'b0, "T2 fill");
    end
    checkVal("T2 sender_svalid", bus.sender_svalid, PAT_5 & ~FRAME_LEN'(16));
    checkVal("T2 receiver_svalid", bus.receiver_svalid, PAT_5 & ~FRAME_LEN'(16));

    // T3: backpressure while the producer keeps pushing
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "T3 stall");
      checkVal("T3 in_ready", FRAME_LEN'(bus.in_ready), FRAME_LEN'(0));
      checkVal("T3 svalid stable", bus.sender_svalid, PAT_5 & ~FRAME_LEN'(16));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "T3 handshake");
    checkVal("T3 in_ready after handshake", FRAME_LEN'(bus.in_ready), FRAME_LEN'(1));
    checkVal("T3 frame_valid after handshake", FRAME_LEN'(bus.frame_valid), FRAME_LEN'(0));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "T3 first event");
    checkVal("T3 slot0 sender_sifted", bus.sender_sifted, FRAME_LEN'(1));

    // T4: flush together with the sixth event, then an empty flush
    for (int k = 1; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "T4 fill");
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "T4 flush");
    checkVal("T4 frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(6));
    checkVal("T4 sender_sifted", bus.sender_sifted, LOW6);
    checkVal("T4 receiver_svalid", bus.receiver_svalid, LOW6);
    idle(1'b1, "T4 handshake");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "T4 empty flush");
    checkVal("T4 empty flush frame_valid", FRAME_LEN'(bus.frame_valid), FRAME_LEN'(0));
    idle(1'b0, "T4 idle");
    checkVal("T4 empty flush frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(0));

    // T5: reset in the middle of a frame
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "T5 fill");
    end
    rst_n = 1'b0;
    mq.delete();
    m_hold = 1'b0;
    #1;
    checkOutput("T5 in reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "T5 restart");
    checkVal("T5 frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(1));
    checkVal("T5 sender_sifted", bus.sender_sifted, FRAME_LEN'(1));
    idle(1'b1, "T5 handshake");

    // T6: three errors on kept slots, two on dropped slots
    for (int k = 0; k < FRAME_LEN; k++) begin
      par = k[0];
      applyStimulus(1'b1, par, 1'b1, par ^ (k == 1 || k == 2 || k == 3 || k == 10 || k == 20),
                    1'b1, !(k == 10 || k == 20), 1'b0, 1'b0, "T6 fill");
    end
    checkVal("T6 frame_fill", FRAME_LEN'(bus.frame_fill), FRAME_LEN'(80));
`ifdef SIFT_QBER_EST_EN
    checkVal("T6 frame_err_cnt", FRAME_LEN'(bus.frame_err_cnt), FRAME_LEN'(3));
`else
    checkVal("T6 frame_err_cnt", FRAME_LEN'(bus.frame_err_cnt), FRAME_LEN'(0));
`endif
    idle(1'b1, "T6 handshake");

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(4) != 0), ($urandom_range(15) == 0),
                    ($urandom_range(2) == 0), "rand");
    end
    idle(1'b1, "drain");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
